id_exe_queue: RTL and testbench
===============================

Name: id_exe_queue

Overview:
- Parametrised successor to the single-entry ID/EX pipeline register: a DEPTH-entry decoupling queue between the ID and EXE stages.
- Uses valid/ready handshakes instead of a stall vector, so EXE back-pressure no longer freezes ID immediately.
- Supports whole-queue flush on jump/branch redirect.
- Exposes a load-use hazard check against every buffered load, so ID can stall correctly with more than one instruction in flight.

Parameters:
- DATA_W, 32, instruction/operand width.
- ADDR_W, 32, instruction address width.
- RADDR_W, 5, register address width.
- DEPTH, 2, queue entries; power of two, >= 2.
- NOP_INST, 32'h00000013, bubble instruction presented when empty.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  ID presents an instruction
- in_ready_o  out  1  queue can accept
- op1_i  in  DATA_W  operand 1
- op2_i  in  DATA_W  operand 2
- reg_we_i  in  1  register write enable
- reg_waddr_i  in  RADDR_W  destination register
- inst_i  in  DATA_W  instruction word
- inst_addr_i  in  ADDR_W  instruction address
- flush_i  in  1  discard all entries (jump/branch redirect)
- out_valid_o  out  1  head entry valid to EXE
- out_ready_i  in  1  EXE consumes head
- op1_o  out  DATA_W  head operand 1
- op2_o  out  DATA_W  head operand 2
- reg_we_o  out  1  head register write enable
- reg_waddr_o  out  RADDR_W  head destination register
- inst_o  out  DATA_W  head instruction
- inst_addr_o  out  ADDR_W  head instruction address
- hz_rs1_i  in  RADDR_W  ID source register 1
- hz_rs2_i  in  RADDR_W  ID source register 2
- load_hazard_o  out  1  a buffered load writes rs1 or rs2
- count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_i=1):
  - Read/write pointers, count, and all per-entry valid bits clear immediately.
  - Payload storage is not cleared.
  - Outputs on and after reset:
    - out_valid_o=0, in_ready_o=1, count_o=0, load_hazard_o=0.
    - inst_o=NOP_INST; op1_o, op2_o, inst_addr_o, reg_waddr_o = 0; reg_we_o=0.
- Push: in_valid_i & in_ready_o at a rising edge.
  - Writes the payload at wptr.
  - Records is_load = (inst_i[6:0] == INST_TYPE_L) and rd = inst_i[11:7] for that entry.
  - wptr increments modulo DEPTH (natural wrap).
- Pop: out_valid_o & out_ready_i at a rising edge; rptr increments modulo DEPTH.
- Handshake rules:
  - in_ready_o = (count < DEPTH), derived from registered count only; no combinational path from out_ready_i.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Full: in_ready_o=0; a pop that cycle does not enable a same-cycle push.
- Outputs:
  - out_valid_o = (count != 0).
  - Head payload is driven combinationally from storage[rptr].
  - When empty, head fields are masked to the bubble values listed under Reset.
  - Payload is held stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput:
  - An instruction pushed at edge N is visible at the output after edge N (1 cycle).
  - Sustained throughput is 1 per cycle when EXE is always ready.
- Flush (flush_i=1 at an edge):
  - count, pointers, and valid bits return to reset values.
  - A simultaneous push is dropped; a simultaneous pop is irrelevant.
  - Flush has priority over push/pop; rst_i has priority over everything.
  - in_ready_o is 1 the cycle after a flush.
- Hazard check (combinational):
  - load_hazard_o = OR over valid entries of (is_load & rd != 0 & (rd == hz_rs1_i | rd == hz_rs2_i)).
  - The head entry counts while valid, including the cycle it is being popped.
  - An entry being pushed in the current cycle does not count.
- count_o: ranges 0..DEPTH; never exceeds DEPTH and never underflows.

Decomposition:
- Shared defines header (existing defines file):
  - INST_TYPE_L opcode, NOP, ZERO constants.
  - Width macros used as parameter defaults (DATA_WIDTH, ADDR_WIDTH, RADDR_WIDTH).
- One natural sub-module, id_exe_queue_entry_cmp:
  - Per-entry hazard comparator (is_load, rd, rs1, rs2 -> hit).
  - Instantiated DEPTH times in a generate loop and OR-reduced.

Test Plan:
- Reset mid-stream: push 2 entries, assert rst_i between clock edges -> out_valid_o, count_o go 0 immediately; inst_o=32'h00000013; in_ready_o=1.
- Streaming: out_ready_i=1, push addr 0x0,0x4,0x8 back-to-back -> outputs appear one cycle later in order; count_o stays 1.
- Back-pressure and wrap (DEPTH=2): out_ready_i=0, push 0x10,0x14 -> count_o=2, in_ready_o=0, head holds 0x10. Third push is refused. Release out_ready_i -> 0x10 then 0x14 out. Push 0x18,0x1C across the wrap -> correct order.
- Flush priority: two entries queued, flush_i=1 with in_valid_i=1 (addr 0x20) -> next cycle count_o=0, out_valid_o=0, 0x20 never emitted.
- Load-use: push lw x5 (inst 0x00002283), hold out_ready_i=0, hz_rs1_i=5 -> load_hazard_o=1; hz_rs1_i=6, hz_rs2_i=0 -> 0. Load writing x0 with hz_rs1_i=0 -> 0.
- Simultaneous push/pop at count=1: push 0x30 while popping 0x2C -> count_o stays 1, head becomes 0x30 next cycle.

Source files
------------

// File: rtl/id_exe_queue_pkg.sv
// Shared ID/EXE constants: opcode, bubble word and default widths.
package id_exe_queue_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned RADDR_WIDTH = 5;

  localparam logic [6:0]  INST_TYPE_L = 7'b0000011;
  localparam logic [31:0] INST_NOP    = 32'h00000013;
  localparam logic [31:0] ZERO        = 32'h00000000;

  function automatic logic is_load_op(input logic [6:0] opcode);
    return opcode == INST_TYPE_L;
  endfunction

endpackage

// File: rtl/id_exe_queue_entry_cmp.sv
// Load-use comparator for one buffered entry; rd == x0 never hazards.
module id_exe_queue_entry_cmp #(
  parameter int unsigned RADDR_W = 5
) (
  input  logic               is_load_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [RADDR_W-1:0] rs1_i,
  input  logic [RADDR_W-1:0] rs2_i,
  output logic               hit_o
);

  assign hit_o = is_load_i & (rd_i != '0) & ((rd_i == rs1_i) | (rd_i == rs2_i));

endmodule

// File: rtl/id_exe_queue.sv
// DEPTH-entry valid/ready queue between ID and EXE with flush and load-use check.
module id_exe_queue
  import id_exe_queue_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_WIDTH,
  parameter int unsigned        ADDR_W   = ADDR_WIDTH,
  parameter int unsigned        RADDR_W  = RADDR_WIDTH,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(INST_NOP)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          op1_i,
  input  logic [DATA_W-1:0]          op2_i,
  input  logic                       reg_we_i,
  input  logic [RADDR_W-1:0]         reg_waddr_i,
  input  logic [DATA_W-1:0]          inst_i,
  input  logic [ADDR_W-1:0]          inst_addr_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          op1_o,
  output logic [DATA_W-1:0]          op2_o,
  output logic                       reg_we_o,
  output logic [RADDR_W-1:0]         reg_waddr_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  input  logic [RADDR_W-1:0]         hz_rs1_i,
  input  logic [RADDR_W-1:0]         hz_rs2_i,
  output logic                       load_hazard_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q;

  logic [DATA_W-1:0]  op1_mem       [DEPTH];
  logic [DATA_W-1:0]  op2_mem       [DEPTH];
  logic               reg_we_mem    [DEPTH];
  logic [RADDR_W-1:0] reg_waddr_mem [DEPTH];
  logic [DATA_W-1:0]  inst_mem      [DEPTH];
  logic [ADDR_W-1:0]  inst_addr_mem [DEPTH];
  logic               is_load_mem   [DEPTH];
  logic [RADDR_W-1:0] rd_mem        [DEPTH];

  logic push, pop;

  // Ready depends only on registered occupancy, so a full queue refuses a push
  // even when EXE drains the head in the same cycle.
  assign in_ready_o  = count_q < CNT_W'(DEPTH);
  assign out_valid_o = count_q != '0;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        wptr_q          <= wptr_q + PTR_W'(1);
        valid_q[wptr_q] <= 1'b1;
      end
      if (pop) begin
        rptr_q          <= rptr_q + PTR_W'(1);
        valid_q[rptr_q] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      op1_mem[wptr_q]       <= op1_i;
      op2_mem[wptr_q]       <= op2_i;
      reg_we_mem[wptr_q]    <= reg_we_i;
      reg_waddr_mem[wptr_q] <= reg_waddr_i;
      inst_mem[wptr_q]      <= inst_i;
      inst_addr_mem[wptr_q] <= inst_addr_i;
      is_load_mem[wptr_q]   <= is_load_op(inst_i[6:0]);
      rd_mem[wptr_q]        <= inst_i[7 +: RADDR_W];
    end
  end

  always_comb begin
    op1_o       = '0;
    op2_o       = '0;
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    inst_o      = NOP_INST;
    inst_addr_o = '0;
    if (out_valid_o) begin
      op1_o       = op1_mem[rptr_q];
      op2_o       = op2_mem[rptr_q];
      reg_we_o    = reg_we_mem[rptr_q];
      reg_waddr_o = reg_waddr_mem[rptr_q];
      inst_o      = inst_mem[rptr_q];
      inst_addr_o = inst_addr_mem[rptr_q];
    end
  end

  logic [DEPTH-1:0] hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    id_exe_queue_entry_cmp #(
      .RADDR_W (RADDR_W)
    ) u_cmp (
      .is_load_i (valid_q[i] & is_load_mem[i]),
      .rd_i      (rd_mem[i]),
      .rs1_i     (hz_rs1_i),
      .rs2_i     (hz_rs2_i),
      .hit_o     (hit[i])
    );
  end

  assign load_hazard_o = |hit;

endmodule

// File: tb/tb_id_exe_queue.sv
// Scoreboard bench for id_exe_queue (DEPTH=2): directed pushes, monitor checks pops.
module tb_id_exe_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  waddr;
  } txn_t;

  localparam logic [31:0] ALU_INST = 32'h00100093;
  localparam logic [31:0] LW_X5    = 32'h00002283;
  localparam logic [31:0] LW_X0    = 32'h00002003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] op1 = '0, op2 = '0, inst = '0, inst_addr = '0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] op1_o, op2_o, inst_o, inst_addr_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [4:0]  hz_rs1 = '0, hz_rs2 = '0;
  logic        load_hazard;
  logic [1:0]  count;

  int   tests = 0;
  int   fails = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  id_exe_queue #(
    .DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .op1_i         (op1),
    .op2_i         (op2),
    .reg_we_i      (reg_we),
    .reg_waddr_i   (reg_waddr),
    .inst_i        (inst),
    .inst_addr_i   (inst_addr),
    .flush_i       (flush),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .reg_we_o      (reg_we_o),
    .reg_waddr_o   (reg_waddr_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .hz_rs1_i      (hz_rs1),
    .hz_rs2_i      (hz_rs2),
    .load_hazard_o (load_hazard),
    .count_o       (count)
  );

  function automatic txn_t make_txn(input logic [31:0] a, input logic [31:0] i);
    txn_t t;
    t.addr  = a;
    t.inst  = i;
    t.op1   = a ^ 32'hA5A5_0000;
    t.op2   = ~a;
    t.we    = a[2];
    t.waddr = a[6:2];
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat; accepted beats are queued as expected outputs.
  task automatic drive(input logic [31:0] a, input logic [31:0] i, input bit accept);
    txn_t t;
    t         = make_txn(a, i);
    in_valid  = 1'b1;
    inst_addr = t.addr;
    inst      = t.inst;
    op1       = t.op1;
    op2       = t.op2;
    reg_we    = t.we;
    reg_waddr = t.waddr;
    if (accept) sb.push_back(t);
  endtask

  // Monitor: a beat is consumed at the next edge when valid & ready.
  always @(negedge clk) begin
    txn_t act, exp;
    if (!rst && out_valid && out_ready) begin
      act = '{addr: inst_addr_o, inst: inst_o, op1: op1_o, op2: op2_o,
              we: reg_we_o, waddr: reg_waddr_o};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got addr %h, expected no output", inst_addr_o);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL output_beat: got addr %h inst %h op1 %h, expected addr %h inst %h op1 %h",
                   act.addr, act.inst, act.op1, exp.addr, exp.inst, exp.op1);
        end
      end
    end
  end

  initial begin
    #2;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_inst_nop", inst_o, 32'h00000013);
    step();
    rst = 1'b0;
    step();

    // Reset mid-stream
    drive(32'h100, ALU_INST, 1'b1);
    step();
    drive(32'h104, ALU_INST, 1'b1);
    step();
    in_valid = 1'b0;
    check("pre_reset_count", {30'b0, count}, 32'd2);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_count", {30'b0, count}, 32'd0);
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_inst", inst_o, 32'h00000013);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("async_rst_addr", inst_addr_o, 32'd0);
    check("async_rst_op1", op1_o, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Streaming with EXE always ready
    out_ready = 1'b1;
    drive(32'h0, ALU_INST, 1'b1);
    step();
    check("stream_count_0", {30'b0, count}, 32'd1);
    check("stream_head_0", inst_addr_o, 32'h0);
    drive(32'h4, ALU_INST, 1'b1);
    step();
    check("stream_count_4", {30'b0, count}, 32'd1);
    check("stream_head_4", inst_addr_o, 32'h4);
    drive(32'h8, ALU_INST, 1'b1);
    step();
    check("stream_count_8", {30'b0, count}, 32'd1);
    in_valid = 1'b0;
    step();
    check("stream_drained", {30'b0, count}, 32'd0);

    // Back-pressure, full refusal, wrap
    out_ready = 1'b0;
    drive(32'h10, ALU_INST, 1'b1);
    step();
    drive(32'h14, ALU_INST, 1'b1);
    step();
    check("full_count", {30'b0, count}, 32'd2);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_head", inst_addr_o, 32'h10);
    drive(32'h99, ALU_INST, 1'b0);
    step();
    check("refused_count", {30'b0, count}, 32'd2);
    check("refused_head_hold", inst_addr_o, 32'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("bp_drained", {30'b0, count}, 32'd0);
    out_ready = 1'b0;
    drive(32'h18, ALU_INST, 1'b1);
    step();
    drive(32'h1C, ALU_INST, 1'b1);
    step();
    check("wrap_head", inst_addr_o, 32'h18);
    // Full with a pop: push must still be refused
    out_ready = 1'b1;
    drive(32'hAA, ALU_INST, 1'b0);
    step();
    check("full_pop_no_push", {30'b0, count}, 32'd1);
    in_valid = 1'b0;
    step();
    check("wrap_drained", {30'b0, count}, 32'd0);

    // Flush beats a simultaneous push
    out_ready = 1'b0;
    drive(32'h40, ALU_INST, 1'b1);
    step();
    drive(32'h44, ALU_INST, 1'b1);
    step();
    drive(32'h20, ALU_INST, 1'b0);
    flush = 1'b1;
    sb.delete();
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", {30'b0, count}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    step();

    // Load-use hazard
    out_ready = 1'b0;
    hz_rs1    = 5'd5;
    hz_rs2    = 5'd0;
    drive(32'h50, LW_X5, 1'b1);
    #1;
    check("hz_pushing_ignored", {31'b0, load_hazard}, 32'd0);
    step();
    in_valid = 1'b0;
    check("hz_rs1_hit", {31'b0, load_hazard}, 32'd1);
    hz_rs1 = 5'd6;
    #1;
    check("hz_miss", {31'b0, load_hazard}, 32'd0);
    hz_rs2 = 5'd5;
    #1;
    check("hz_rs2_hit", {31'b0, load_hazard}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("hz_head_popping", {31'b0, load_hazard}, 32'd1);
    step();
    check("hz_after_pop", {31'b0, load_hazard}, 32'd0);
    out_ready = 1'b0;
    hz_rs1    = 5'd0;
    hz_rs2    = 5'd0;
    drive(32'h54, LW_X0, 1'b1);
    step();
    in_valid = 1'b0;
    check("hz_x0_ignored", {31'b0, load_hazard}, 32'd0);
    out_ready = 1'b1;
    step();

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    drive(32'h2C, ALU_INST, 1'b1);
    step();
    out_ready = 1'b1;
    drive(32'h30, ALU_INST, 1'b1);
    step();
    in_valid = 1'b0;
    check("pushpop_count", {30'b0, count}, 32'd1);
    check("pushpop_head", inst_addr_o, 32'h30);
    step();
    check("final_count", {30'b0, count}, 32'd0);
    step();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
